// File: rtl/seg7_pkg.sv
// Shared constants, glyph table and decode helper
// for the four-digit seven-segment display blocks.
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] AN_OFF    = 4'hF;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0010000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } scan_state_t;

  function automatic logic [6:0] hex_to_seg(
    input logic [3:0] nibble
  );
    logic [6:0] s;
    unique case (nibble)
      4'h0: s = GLYPH_0;
      4'h1: s = GLYPH_1;
      4'h2: s = GLYPH_2;
      4'h3: s = GLYPH_3;
      4'h4: s = GLYPH_4;
      4'h5: s = GLYPH_5;
      4'h6: s = GLYPH_6;
      4'h7: s = GLYPH_7;
      4'h8: s = GLYPH_8;
      4'h9: s = GLYPH_9;
      4'hA: s = GLYPH_A;
      4'hB: s = GLYPH_B;
      4'hC: s = GLYPH_C;
      4'hD: s = GLYPH_D;
      4'hE: s = GLYPH_E;
      4'hF: s = GLYPH_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Display bundle: digit data/enables in,
// multiplexed anode/segment pins out.
interface seg7_scan_ctrl_if;

  logic [15:0] digits_in;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        slot_tick;

  modport master (
    output digits_in,
    output dp_in,
    output digit_en,
    input  an,
    input  seg,
    input  dp,
    input  slot_tick
  );

  modport slave (
    input  digits_in,
    input  dp_in,
    input  digit_en,
    output an,
    output seg,
    output dp,
    output slot_tick
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low
// {g..a} segment pattern.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Four-digit common-anode scan controller
// with per-slot dead time on clk_50mhz.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic              clk_50mhz,
  input  logic              rst,
  seg7_scan_ctrl_if.slave   bus
);

  localparam int CW =
    (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'(SLOT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_END =
    CW'(BLANK_CYCLES);

  if (BLANK_CYCLES < 1 ||
      BLANK_CYCLES >= SLOT_CYCLES) begin : g_bad_blank
    $error("seg7_scan_ctrl: BLANK_CYCLES out of range");
  end

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic [1:0]    idx;
  logic [1:0]    idx_next;
  logic          wrap;
  logic [3:0]    nibble;
  logic [6:0]    glyph;
  logic          en_q;
  scan_state_t   state;

  always_comb begin
    wrap     = (cnt == CNT_LAST);
    cnt_next = wrap ? '0 : cnt + 1'b1;
    idx_next = wrap ? idx + 2'd1 : idx;
    nibble   = bus.digits_in[4*idx_next +: 4];
  end

  seg7_hex_decode u_dec (
    .nibble (nibble),
    .seg    (glyph)
  );

  // Inputs are sampled only at the slot wrap so
  // the pins hold steady for the whole slot.
  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      cnt           <= CNT_LAST;
      idx           <= 2'd3;
      en_q          <= 1'b0;
      state         <= ST_BLANK;
      bus.an        <= AN_OFF;
      bus.seg       <= SEG_BLANK;
      bus.dp        <= 1'b1;
      bus.slot_tick <= 1'b0;
    end else begin
      cnt           <= cnt_next;
      idx           <= idx_next;
      bus.slot_tick <= wrap;
      if (wrap) begin
        en_q   <= bus.digit_en[idx_next];
        state  <= ST_BLANK;
        bus.an <= AN_OFF;
        if (bus.digit_en[idx_next]) begin
          bus.seg <= glyph;
          bus.dp  <= ~bus.dp_in[idx_next];
        end else begin
          bus.seg <= SEG_BLANK;
          bus.dp  <= 1'b1;
        end
      end else if (state == ST_BLANK &&
                   cnt_next == BLANK_END) begin
        state  <= ST_DRIVE;
        bus.an <= en_q ? ~(4'b0001 << idx) : AN_OFF;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with
// 16-cycle slots and 3-cycle dead time.
module tb_seg7_scan_ctrl;

  localparam int SLOT  = 16;
  localparam int BLANK = 3;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  logic clk_50mhz = 1'b0;
  logic rst       = 1'b1;
  int   tests     = 0;
  int   fails     = 0;

  seg7_scan_ctrl_if bus ();

  seg7_scan_ctrl #(
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) dut (
    .clk_50mhz (clk_50mhz),
    .rst       (rst),
    .bus       (bus)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  always @(negedge clk_50mhz) begin
    if ($countones(~bus.an) > 1) begin
      fails++;
      $display("FAIL one_hot_an: got %b want <=1 low",
               bus.an);
    end
  end

  task automatic tick;
    @(negedge clk_50mhz);
  endtask

  function automatic logic [3:0] exp_an(
    input int s, input int c, input logic [3:0] en
  );
    if (c < BLANK || !en[s]) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  task automatic test_reset;
    bus.digits_in = 16'h1234;
    bus.digit_en  = 4'hF;
    bus.dp_in     = 4'h0;
    rst = 1'b1;
    repeat (5) begin
      tick;
      tests++;
      if ({bus.an, bus.seg, bus.dp, bus.slot_tick} !==
          {4'hF, 7'h7F, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL reset_hold: got %b/%h/%b/%b want 1111/7f/1/0",
                 bus.an, bus.seg, bus.dp, bus.slot_tick);
      end
    end
    rst = 1'b0;
    tick;
    tests++;
    if ({bus.slot_tick, bus.an, bus.seg} !==
        {1'b1, 4'hF, 7'h19}) begin
      fails++;
      $display("FAIL reset_release: got %b/%b/%h want 1/1111/19",
               bus.slot_tick, bus.an, bus.seg);
    end
    repeat (63) tick;
  endtask

  task automatic test_scan;
    logic [6:0] es [4] = '{7'h19, 7'h30, 7'h24, 7'h79};
    bus.digits_in = 16'h1234;
    bus.digit_en  = 4'hF;
    bus.dp_in     = 4'h0;
    for (int i = 0; i < 64; i++) begin
      int s = i / SLOT;
      int c = i % SLOT;
      tick;
      tests++;
      if (bus.an !== exp_an(s, c, 4'hF) ||
          bus.seg !== es[s] || bus.dp !== 1'b1 ||
          bus.slot_tick !== (c == 0)) begin
        fails++;
        $display("FAIL scan s%0d c%0d: got %b/%h/%b/%b want %b/%h/1/%b",
                 s, c, bus.an, bus.seg, bus.dp, bus.slot_tick,
                 exp_an(s, c, 4'hF), es[s], c == 0);
      end
    end
  endtask

  task automatic test_enable;
    logic [6:0] es [4] = '{7'h19, 7'h30, 7'h7F, 7'h79};
    bus.digit_en = 4'b1011;
    for (int i = 0; i < 64; i++) begin
      int s = i / SLOT;
      int c = i % SLOT;
      tick;
      tests++;
      if (bus.an !== exp_an(s, c, 4'b1011) ||
          bus.seg !== es[s] ||
          bus.slot_tick !== (c == 0)) begin
        fails++;
        $display("FAIL enable s%0d c%0d: got %b/%h/%b want %b/%h/%b",
                 s, c, bus.an, bus.seg, bus.slot_tick,
                 exp_an(s, c, 4'b1011), es[s], c == 0);
      end
    end
    bus.digit_en = 4'hF;
  endtask

  task automatic test_capture;
    bus.digits_in = 16'h1238;
    for (int i = 0; i < 64; i++) begin
      tick;
      if (i == 7) bus.digits_in = 16'h123F;
      if (i < SLOT) begin
        tests++;
        if (bus.seg !== 7'h00) begin
          fails++;
          $display("FAIL capture_hold c%0d: got %h want 00",
                   i, bus.seg);
        end
      end
    end
    tick;
    tests++;
    if (bus.seg !== 7'h0E || bus.slot_tick !== 1'b1) begin
      fails++;
      $display("FAIL capture_next: got %h/%b want 0e/1",
               bus.seg, bus.slot_tick);
    end
    repeat (63) tick;
    bus.digits_in = 16'h1234;
  endtask

  task automatic test_dp;
    bus.dp_in = 4'b0100;
    for (int i = 0; i < 64; i++) begin
      int s = i / SLOT;
      tick;
      tests++;
      if (bus.dp !== (s != 2)) begin
        fails++;
        $display("FAIL dp s%0d c%0d: got %b want %b",
                 s, i % SLOT, bus.dp, s != 2);
      end
    end
    bus.dp_in = 4'h0;
  endtask

  task automatic test_reset_mid;
    repeat (42) tick;
    tests++;
    if (bus.an !== 4'b1011 || bus.seg !== 7'h24) begin
      fails++;
      $display("FAIL mid_pre: got %b/%h want 1011/24",
               bus.an, bus.seg);
    end
    rst = 1'b1;
    tick;
    tests++;
    if ({bus.an, bus.seg, bus.dp, bus.slot_tick} !==
        {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL mid_reset: got %b/%h/%b/%b want 1111/7f/1/0",
               bus.an, bus.seg, bus.dp, bus.slot_tick);
    end
    tick;
    rst = 1'b0;
    tick;
    tests++;
    if ({bus.slot_tick, bus.an, bus.seg} !==
        {1'b1, 4'hF, 7'h19}) begin
      fails++;
      $display("FAIL mid_restart: got %b/%b/%h want 1/1111/19",
               bus.slot_tick, bus.an, bus.seg);
    end
    repeat (3) tick;
    tests++;
    if (bus.an !== 4'b1110) begin
      fails++;
      $display("FAIL mid_drive0: got %b want 1110", bus.an);
    end
  endtask

  initial begin
    test_reset;
    test_scan;
    test_enable;
    test_capture;
    test_dp;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
